// File: rtl/hull_rasterizer_pkg.sv
// Shared constants for the hull outline rasterizer: coordinate/error widths
// and the controller state encoding.
package hull_rasterizer_pkg;

  localparam int COORD_W = 11;
  localparam int ERR_W   = COORD_W + 2;

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_DRAW    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef logic signed [ERR_W-1:0] err_t;

endpackage

// File: rtl/hull_rasterizer_bresenham_stepper.sv
// Bresenham line walker: latches one edge on load, then moves the cursor one
// pixel toward (x1,y1) on each advance.
module bresenham_stepper #(
  parameter int COORD_W = hull_rasterizer_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               advance,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               at_end
);

  localparam int EW = COORD_W + 2;

  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [EW-1:0] ux0, uy0, ux1, uy1;
  logic signed [EW:0] e2, dx_w, dy_w;
  logic step_x, step_y;

  assign ux0 = {2'b00, x0};
  assign uy0 = {2'b00, y0};
  assign ux1 = {2'b00, x1};
  assign uy1 = {2'b00, y1};

  // One extra bit so 2*err cannot overflow at full-range edges.
  assign e2     = {err_q, 1'b0};
  assign dx_w   = {dx_q[EW-1], dx_q};
  assign dy_w   = {dy_q[EW-1], dy_q};
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  always_comb begin
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    if (load) begin
      x1_d     = x1;
      y1_d     = y1;
      cur_x_d  = x0;
      cur_y_d  = y0;
      sx_neg_d = !(x0 < x1);
      sy_neg_d = !(y0 < y1);
      dx_d     = (x1 >= x0) ? $signed(ux1 - ux0) : $signed(ux0 - ux1);
      dy_d     = (y1 >= y0) ? $signed(uy0 - uy1) : $signed(uy1 - uy0);
      err_d    = dx_d + dy_d;
    end else if (advance) begin
      if (step_x) cur_x_d = sx_neg_q ? cur_x_q - 1'b1 : cur_x_q + 1'b1;
      if (step_y) cur_y_d = sy_neg_q ? cur_y_q - 1'b1 : cur_y_q + 1'b1;
      err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign cur_x  = cur_x_q;
  assign cur_y  = cur_y_q;
  assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

endmodule

// File: rtl/hull_rasterizer.sv
// Buffers a convex-hull vertex list and streams its closed outline, one pixel
// per valid/ready handshake, walking each edge with a Bresenham stepper.
module hull_rasterizer #(
  parameter int MAX_VERTS = 256,
  parameter int COORD_W   = hull_rasterizer_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         vert_in,
  input  logic [COORD_W-1:0] vert_x,
  input  logic [COORD_W-1:0] vert_y,
  input  logic               vert_done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  import hull_rasterizer_pkg::*;

  localparam int CW = $clog2(MAX_VERTS + 1);
  localparam int AW = (MAX_VERTS > 1) ? $clog2(MAX_VERTS) : 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d, e_q, e_d;
  logic          load_ph_q, load_ph_d;
  logic          emitted_q, emitted_d;
  logic          overflow_q, overflow_d;

  logic                 vert_valid, mem_we, step_load, step_advance, at_end, edge_end;
  logic [AW-1:0]        mem_waddr, e_next;
  logic [CW-1:0]        e_inc;
  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [2*COORD_W-1:0] mem [MAX_VERTS];
  logic [2*COORD_W-1:0] rd_a_q, rd_b_q;

  assign vert_valid = |vert_in;
  assign e_inc      = e_q + CW'(1);
  assign e_next     = (e_inc == count_q) ? '0 : e_inc[AW-1:0];

  // A lone vertex is a zero-length edge that must still emit its one pixel.
  assign edge_end     = at_end && !((count_q == CW'(1)) && !emitted_q);
  assign pix_valid    = (state_q == ST_DRAW) && !edge_end;
  assign step_advance = pix_valid && pix_ready && !at_end;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    e_d        = e_q;
    load_ph_d  = load_ph_q;
    emitted_d  = emitted_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = count_q[AW-1:0];
    step_load  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (vert_valid) begin
          if (count_q == CW'(MAX_VERTS)) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        if (vert_done) state_d = (count_d == '0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: begin
        e_d       = '0;
        load_ph_d = 1'b0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        // First cycle lets the RAM read both endpoints; second cycle loads them.
        if (!load_ph_q) begin
          load_ph_d = 1'b1;
        end else begin
          load_ph_d = 1'b0;
          step_load = 1'b1;
          emitted_d = 1'b0;
          state_d   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (edge_end) begin
          e_d     = e_inc;
          state_d = (e_inc == count_q) ? ST_DONE : ST_LOAD;
        end else if (pix_ready) begin
          emitted_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (vert_valid) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          count_d    = CW'(1);
          overflow_d = 1'b0;
          state_d    = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      count_q    <= '0;
      e_q        <= '0;
      load_ph_q  <= 1'b0;
      emitted_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      e_q        <= e_d;
      load_ph_q  <= load_ph_d;
      emitted_q  <= emitted_d;
      overflow_q <= overflow_d;
    end
  end

  // Vertex RAM: one write port, two registered read ports for the edge ends.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= {vert_x, vert_y};
    rd_a_q <= mem[e_q[AW-1:0]];
    rd_b_q <= mem[e_next];
  end

  bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (step_load),
    .x0      (rd_a_q[2*COORD_W-1:COORD_W]),
    .y0      (rd_a_q[COORD_W-1:0]),
    .x1      (rd_b_q[2*COORD_W-1:COORD_W]),
    .y1      (rd_b_q[COORD_W-1:0]),
    .advance (step_advance),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .at_end  (at_end)
  );

  assign pix_x    = cur_x;
  assign pix_y    = cur_y;
  assign busy     = (state_q == ST_SETUP) || (state_q == ST_LOAD) || (state_q == ST_DRAW);
  assign done     = (state_q == ST_DONE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hull_rasterizer.sv
// Scoreboard bench for hull_rasterizer: expected outline pixels are queued as
// stimulus is driven and compared as each pixel is accepted.
module tb_hull_rasterizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vert_in = 8'h00;
  logic [10:0] vert_x = '0, vert_y = '0;
  logic        vert_done = 1'b0;
  logic        pix_ready = 1'b0;
  logic        sel4 = 1'b0;

  logic [7:0]  vin_a, vin_b;
  logic        vd_a, vd_b;
  logic        pv_a, busy_a, done_a, ovf_a;
  logic        pv_b, busy_b, done_b, ovf_b;
  logic [10:0] px_a, py_a, px_b, py_b;
  logic        m_valid, m_busy, m_done;
  logic [10:0] m_x, m_y;

  assign vin_a   = sel4 ? 8'h00 : vert_in;
  assign vin_b   = sel4 ? vert_in : 8'h00;
  assign vd_a    = sel4 ? 1'b0 : vert_done;
  assign vd_b    = sel4 ? vert_done : 1'b0;
  assign m_valid = sel4 ? pv_b : pv_a;
  assign m_busy  = sel4 ? busy_b : busy_a;
  assign m_done  = sel4 ? done_b : done_a;
  assign m_x     = sel4 ? px_b : px_a;
  assign m_y     = sel4 ? py_b : py_a;

  hull_rasterizer dut (
    .clk(clk), .rst(rst), .vert_in(vin_a), .vert_x(vert_x), .vert_y(vert_y),
    .vert_done(vd_a), .pix_valid(pv_a), .pix_ready(pix_ready), .pix_x(px_a),
    .pix_y(py_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  hull_rasterizer #(.MAX_VERTS(4)) dut4 (
    .clk(clk), .rst(rst), .vert_in(vin_b), .vert_x(vert_x), .vert_y(vert_y),
    .vert_done(vd_b), .pix_valid(pv_b), .pix_ready(pix_ready), .pix_x(px_b),
    .pix_y(py_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  int valid_cycles = 0;
  logic [21:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [10:0] prev_x = '0, prev_y = '0;

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [21:0] exp_pix;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_valid) begin
        checks++;
        if (m_x !== prev_x || m_y !== prev_y) begin
          errors++;
          $display("FAIL stall_hold: got (%0d,%0d) required (%0d,%0d)", m_x, m_y, prev_x, prev_y);
        end
      end
      if (m_valid) valid_cycles++;
      if (m_valid && pix_ready) begin
        accepted++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra: got (%0d,%0d) required no pixel", m_x, m_y);
        end else begin
          exp_pix = exp_q.pop_front();
          if ({m_x, m_y} !== exp_pix) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) required (%0d,%0d)", m_x, m_y,
                     exp_pix[21:11], exp_pix[10:0]);
          end else begin
            $display("pixel (%0d,%0d) ok", m_x, m_y);
          end
        end
      end
      prev_stall = m_valid && !pix_ready;
      prev_x = m_x;
      prev_y = m_y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y);
    exp_q.push_back({11'(x), 11'(y)});
  endtask

  task automatic send_vertex(input int x, input int y);
    vert_in = 8'hFF;
    vert_x  = 11'(x);
    vert_y  = 11'(y);
    tick();
    vert_in = 8'h00;
  endtask

  task automatic pulse_done();
    vert_done = 1'b1;
    tick();
    vert_done = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while (!(m_done && !m_busy) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0d done=%0d required done=1", name, m_busy, m_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d pixels outstanding required 0", name, exp_q.size());
    end
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: got done=%0d busy=%0d required done=1 busy=0", name, m_done, m_busy);
    end
  endtask

  task automatic push_triangle();
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0); push(3, 1);
    push(2, 2); push(1, 3); push(0, 4); push(0, 3); push(0, 2); push(0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({pv_a, busy_a, done_a, ovf_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got v/b/d/o=%b required 0000", {pv_a, busy_a, done_a, ovf_a});
    end
    checks++;
    if (px_a !== 11'd0 || py_a !== 11'd0) begin
      errors++;
      $display("FAIL reset_pix: got (%0d,%0d) required (0,0)", px_a, py_a);
    end
    checks++;
    if ({pv_b, busy_b, done_b, ovf_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags4: got v/b/d/o=%b required 0000", {pv_b, busy_b, done_b, ovf_b});
    end
    rst = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_triangle();
    int lat = 1;
    push_triangle();
    send_vertex(0, 0);
    send_vertex(4, 0);
    send_vertex(0, 4);
    pix_ready = 1'b1;
    pulse_done();
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat > 4) begin
      errors++;
      $display("FAIL first_pixel_latency: got %0d cycles required <= 4", lat);
    end
    wait_finish("triangle");
  endtask

  task automatic test_stall();
    int n = 0;
    int base = accepted;
    push_triangle();
    send_vertex(0, 0);
    send_vertex(4, 0);
    send_vertex(0, 4);
    pix_ready = 1'b1;
    pulse_done();
    while (!(m_done && !m_busy) && n < 400) begin
      tick();
      pix_ready = ~pix_ready;
      n++;
    end
    pix_ready = 1'b1;
    wait_finish("stall");
    checks++;
    if (accepted - base != 12) begin
      errors++;
      $display("FAIL stall_count: got %0d pixels required 12", accepted - base);
    end
  endtask

  task automatic test_single();
    int base = valid_cycles;
    push(5, 7);
    send_vertex(5, 7);
    pulse_done();
    wait_finish("single");
    checks++;
    if (valid_cycles - base != 1) begin
      errors++;
      $display("FAIL single_count: got %0d valid cycles required 1", valid_cycles - base);
    end
  endtask

  task automatic test_two();
    push(0, 0); push(1, 1); push(2, 1); push(1, 0);
    send_vertex(0, 0);
    send_vertex(2, 1);
    pulse_done();
    wait_finish("two_vertex");
  endtask

  task automatic test_overflow();
    sel4 = 1'b1;
    push(0, 0); push(1, 0); push(2, 0); push(2, 1);
    push(2, 2); push(1, 2); push(0, 2); push(0, 1);
    send_vertex(0, 0);
    send_vertex(2, 0);
    send_vertex(2, 2);
    send_vertex(0, 2);
    checks++;
    if (ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL overflow_at_limit: got %0d required 0", ovf_b);
    end
    send_vertex(9, 9);
    send_vertex(9, 8);
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %0d required 1", ovf_b);
    end
    pulse_done();
    wait_finish("overflow");
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %0d required 1", ovf_b);
    end
    push(3, 3);
    send_vertex(3, 3);
    checks++;
    if (ovf_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%0d done=%0d required 0 0", ovf_b, done_b);
    end
    pulse_done();
    wait_finish("after_overflow");
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid_draw();
    int n = 0;
    int base = accepted;
    push_triangle();
    send_vertex(0, 0);
    send_vertex(4, 0);
    send_vertex(0, 4);
    pix_ready = 1'b1;
    pulse_done();
    while (accepted - base < 2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50 || pv_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach: got accepted=%0d valid=%0d required 2 and 1", accepted - base, pv_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: got valid=%0d busy=%0d required 0 0", pv_a, busy_a);
    end
    rst = 1'b0;
    exp_q.delete();
    push(1, 1);
    send_vertex(1, 1);
    pulse_done();
    wait_finish("after_reset");
  endtask

  task automatic test_empty();
    int base;
    int n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = valid_cycles;
    pulse_done();
    while (!done_a && n < 2) begin
      tick();
      n++;
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: got done=%0d busy=%0d required 1 0", done_a, busy_a);
    end
    repeat (5) tick();
    checks++;
    if (valid_cycles != base) begin
      errors++;
      $display("FAIL empty_pixels: got %0d valid cycles required 0", valid_cycles - base);
    end
    $display("empty list checked");
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_stall();
    test_single();
    test_two();
    test_overflow();
    test_reset_mid_draw();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hull_rasterizer.md
Name: hull_rasterizer

Overview:
- Consumes the convex-hull vertex stream produced by the hull extractor: a strobe plus 11-bit x/y per vertex, in hull order.
- Buffers the vertices, then rasterises the closed polygon outline with Bresenham line stepping, including the closing edge from the last vertex back to the first.
- Emits one outline pixel per valid/ready handshake toward the overlay/VGA draw path.

Parameters:
- MAX_VERTS, 256, vertex buffer depth; vertices beyond this are dropped.
- COORD_W, 11, coordinate width for x and y.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- vert_in  in  8  vertex strobe; any non-zero value marks a valid vertex (matches the extractor's 8'hFF strobe)
- vert_x  in  COORD_W  vertex x
- vert_y  in  COORD_W  vertex y
- vert_done  in  1  one-cycle pulse: vertex list complete
- pix_valid  out  1  outline pixel available
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  COORD_W  pixel x
- pix_y  out  COORD_W  pixel y
- busy  out  1  high from vert_done until draw finished
- done  out  1  high in DONE until the next vertex arrives
- overflow  out  1  sticky: more than MAX_VERTS vertices offered

Behaviour:
- Reset (synchronous, active-high, takes priority over everything): state=COLLECT, count=0; pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0, overflow=0. Reset mid-draw abandons the draw; pix_valid is 0 on the cycle after rst.
- COLLECT:
  - Each cycle with vert_in!=0 writes (vert_x,vert_y) to buffer[count], count++.
  - If count==MAX_VERTS, the vertex is dropped and overflow is set.
  - vert_done (including when coincident with a vertex, which is stored first) -> SETUP with busy=1.
  - count==0 -> DONE directly; no pixel is emitted.
- DONE: done=1. The next vert_in!=0 clears done, resets count to 0 and overflow to 0, stores that vertex, and returns to COLLECT. vert_done in DONE is ignored.
- Vertex input while busy (SETUP/LOAD/DRAW) is ignored; the producer must not send.
- SETUP:
  - Edge index e=0.
  - LOAD: read buffer[e] as (x0,y0) and buffer[(e+1) mod count] as (x1,y1). A registered read is allowed; LOAD takes at most 2 cycles.
  - Then compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy, all signed COORD_W+2 bits. Cursor=(x0,y0). -> DRAW.
- DRAW, per edge: pixels run from the start vertex inclusive to the end vertex exclusive, so every vertex is emitted exactly once across the closed outline.
  - If cursor==(x1,y1): edge complete; e++. If e==count -> DONE (busy=0); else -> LOAD.
  - Otherwise present the cursor on pix_x/pix_y with pix_valid=1.
  - On a cycle where pix_valid&&pix_ready, step: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both steps may apply on the same cycle.
  - pix_x/pix_y are held stable while pix_valid&&!pix_ready.
- Single vertex (count==1): emit exactly one pixel (x0,y0), then DONE. This is the zero-length-edge special case.
- Two vertices: the outline is drawn v0->v1 and then v1->v0.
- Throughput: one pixel per cycle within an edge under pix_ready=1. Edge-to-edge gap is at most 3 idle cycles. First pix_valid appears at most 4 cycles after vert_done.
- Coordinates never leave the [min,max] of the edge endpoints, so no wrap handling is required.

Decomposition:
- Shared package:
  - COORD_W
  - state encoding: COLLECT, SETUP, LOAD, DRAW, DONE
  - signed error width COORD_W+2
- Sub-module bresenham_stepper:
  - inputs: load, x0, y0, x1, y1, advance
  - outputs: cur_x, cur_y, at_end
  - owns dx/dy/err/sx/sy
- Top module holds the vertex RAM, the edge counter, and the handshake.

Test Plan:
- Triangle (0,0),(4,0),(0,4), vert_done, pix_ready=1 -> exactly 12 pixels in order: (0,0),(1,0),(2,0),(3,0),(4,0),(3,1),(2,2),(1,3),(0,4),(0,3),(0,2),(0,1); then done=1, busy=0.
- Same triangle with pix_ready alternating 1,0 -> identical sequence; pix_x/pix_y unchanged on every stalled cycle; no pixel lost or duplicated.
- Single vertex (5,7) then vert_done -> one pixel (5,7), then done.
- vert_done with no vertices -> done=1 within 2 cycles; pix_valid never asserted.
- MAX_VERTS=4, square (0,0),(2,0),(2,2),(0,2) plus extras (9,9),(9,8) -> overflow=1; 8 pixels drawn from the first 4 vertices only.
- rst asserted on the 3rd pixel of the triangle -> pix_valid=0 and busy=0 on the next cycle; a fresh 1-vertex list (1,1) afterwards emits (1,1).
